mem_line_responder: RTL and testbench

- Memory-side responder for the line-based request/response bus that caches use on their memory port.
- Accepts a line address plus tag, then serves it as a read or a write:
  - read: returns eight 64-bit beats after a programmable latency;
  - write: absorbs eight 64-bit beats into a register-based backing store.
- Serves as the DRAM model behind set_cache in simulation and as the template for the real memory controller front end.

---
 rtl/mem_line_responder.sv | 133 +++++++++++++
 tb/tb_mem_line_responder.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_line_responder.sv
// Memory-side responder for the line request/response bus: accepts a line address
// and tag, then streams a whole line out (read) or absorbs one into a register store (write).
module mem_line_responder #(
    parameter int BUS_DATA_WIDTH = 64,
    parameter int BUS_TAG_WIDTH  = 13,
    parameter int LINE_BEATS     = 8,
    parameter int OFFSET         = 6,
    parameter int MEM_LINES      = 16,
    parameter int READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    output logic                      bus_reqack,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_respcyc,
    input  logic                      bus_respack,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag
);

    localparam int LINE_W = (MEM_LINES > 1) ? $clog2(MEM_LINES) : 1;
    localparam int BEAT_W = (LINE_BEATS > 1) ? $clog2(LINE_BEATS) : 1;
    localparam int LAT_W  = (READ_LATENCY > 0) ? $clog2(READ_LATENCY + 1) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_ACK, S_WR_WAIT, S_WR_ACK, S_RD_WAIT, S_RD_BEAT, S_RD_GAP
    } state_t;

    state_t                    state_q, state_d;
    logic [LINE_W-1:0]         line_q, line_d;
    logic [BUS_TAG_WIDTH-1:0]  tag_q, tag_d;
    logic [BEAT_W-1:0]         beat_q, beat_d;
    logic [LAT_W-1:0]          lat_q, lat_d;
    logic                      wr_en;
    logic                      reqack_q, respcyc_q;
    logic [BUS_DATA_WIDTH-1:0] resp_q;
    logic [BUS_TAG_WIDTH-1:0]  resptag_q;
    logic [BUS_DATA_WIDTH-1:0] store_q [MEM_LINES][LINE_BEATS];

    always_comb begin
        state_d = state_q;
        line_d  = line_q;
        tag_d   = tag_q;
        beat_d  = beat_q;
        lat_d   = lat_q;
        wr_en   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus_reqcyc) begin
                    line_d  = bus_req[OFFSET +: LINE_W];
                    tag_d   = bus_reqtag;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                beat_d = '0;
                // The wait state is occupied for exactly READ_LATENCY cycles, so it
                // is loaded one short and skipped entirely for zero latency.
                if (tag_q[BUS_TAG_WIDTH-1]) begin
                    if (READ_LATENCY == 0) begin
                        state_d = S_RD_BEAT;
                    end else begin
                        lat_d   = LAT_W'(READ_LATENCY - 1);
                        state_d = S_RD_WAIT;
                    end
                end else begin
                    state_d = S_WR_WAIT;
                end
            end
            S_WR_WAIT: begin
                if (bus_reqcyc) begin
                    wr_en   = 1'b1;
                    state_d = S_WR_ACK;
                end
            end
            S_WR_ACK: begin
                beat_d  = beat_q + BEAT_W'(1);
                state_d = (beat_q == BEAT_W'(LINE_BEATS - 1)) ? S_IDLE : S_WR_WAIT;
            end
            S_RD_WAIT: begin
                if (lat_q == '0) state_d = S_RD_BEAT;
                else             lat_d   = lat_q - LAT_W'(1);
            end
            S_RD_BEAT: begin
                if (bus_respack) begin
                    beat_d  = beat_q + BEAT_W'(1);
                    state_d = (beat_q == BEAT_W'(LINE_BEATS - 1)) ? S_IDLE : S_RD_GAP;
                end
            end
            S_RD_GAP: state_d = S_RD_BEAT;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            line_q    <= '0;
            tag_q     <= '0;
            beat_q    <= '0;
            lat_q     <= '0;
            reqack_q  <= 1'b0;
            respcyc_q <= 1'b0;
            resp_q    <= '0;
            resptag_q <= '0;
            for (int l = 0; l < MEM_LINES; l++) begin
                for (int b = 0; b < LINE_BEATS; b++) begin
                    store_q[l][b] <= '0;
                end
            end
        end else begin
            state_q   <= state_d;
            line_q    <= line_d;
            tag_q     <= tag_d;
            beat_q    <= beat_d;
            lat_q     <= lat_d;
            // Outputs are registered from the next state so they align with it.
            reqack_q  <= (state_d == S_ACK) || (state_d == S_WR_ACK);
            respcyc_q <= (state_d == S_RD_BEAT);
            resp_q    <= (state_d == S_RD_BEAT) ? store_q[line_q][beat_d] : '0;
            resptag_q <= (state_d == S_RD_BEAT) ? tag_q : '0;
            if (wr_en) store_q[line_q][beat_q] <= bus_req;
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = respcyc_q;
    assign bus_resp    = resp_q;
    assign bus_resptag = resptag_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized bench for mem_line_responder against a line-array reference model.
module tb_mem_line_responder;

    localparam int DW = 64;
    localparam int TW = 13;
    localparam int NB = 8;
    localparam int NL = 16;
    localparam int RL = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
    logic [DW-1:0] bus_req, bus_resp;
    logic [TW-1:0] bus_reqtag, bus_resptag;

    logic          z_reqcyc, z_reqack, z_respcyc, z_respack;
    logic [DW-1:0] z_req, z_resp;
    logic [TW-1:0] z_reqtag, z_resptag;

    logic [DW-1:0] model [NL][NB];
    logic [DW-1:0] wbuf [NB];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_line_responder #(.READ_LATENCY(RL)) u_dut (
        .clk(clk), .reset(reset),
        .bus_reqcyc(bus_reqcyc), .bus_reqack(bus_reqack),
        .bus_req(bus_req), .bus_reqtag(bus_reqtag),
        .bus_respcyc(bus_respcyc), .bus_respack(bus_respack),
        .bus_resp(bus_resp), .bus_resptag(bus_resptag)
    );

    mem_line_responder #(.READ_LATENCY(0)) u_dut_lat0 (
        .clk(clk), .reset(reset),
        .bus_reqcyc(z_reqcyc), .bus_reqack(z_reqack),
        .bus_req(z_req), .bus_reqtag(z_reqtag),
        .bus_respcyc(z_respcyc), .bus_respack(z_respack),
        .bus_resp(z_resp), .bus_resptag(z_resptag)
    );

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int line_of(input logic [63:0] a);
        return int'(a[9:6]);
    endfunction

    task automatic clear_model();
        for (int l = 0; l < NL; l++)
            for (int b = 0; b < NB; b++)
                model[l][b] = '0;
    endtask

    // Write the line held in wbuf; gapmax>0 inserts random reqcyc-low cycles before beats.
    task automatic do_write(input logic [63:0] addr, input logic [TW-1:0] tag, input int gapmax);
        int g, n;
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
        step();
        chk("wr_addr_ack", bus_reqack, 1);
        for (int k = 0; k < NB; k++) begin
            g = (gapmax > 0) ? int'($urandom_range(gapmax, 0)) : 0;
            if (g > 0) begin
                bus_reqcyc = 1'b0;
                repeat (g) begin
                    step();
                    chk("wr_gap_noack", bus_reqack, 0);
                end
            end
            bus_reqcyc = 1'b1; bus_req = wbuf[k];
            n = 0;
            do begin
                step();
                n++;
            end while (!bus_reqack && n < 10);
            chk("wr_beat_ack", bus_reqack, 1);
            chk("wr_beat_spacing", n, (g == 0) ? 2 : 1);
            chk("wr_no_respcyc", bus_respcyc, 0);
        end
        bus_reqcyc = 1'b0;
        for (int k = 0; k < NB; k++) model[line_of(addr)][k] = wbuf[k];
        step();
        chk("wr_done_noack", bus_reqack, 0);
    endtask

    // Read a line; respack after mind..maxd stall cycles; busy keeps reqcyc high throughout;
    // rst_beat>=0 asserts reset asynchronously while that beat is presented.
    task automatic do_read(input logic [63:0] addr, input logic [TW-1:0] tag, input int mind,
                           input int maxd, input logic busy, input int rst_beat);
        int idle, d, ln;
        logic [DW-1:0] held;
        ln = line_of(addr);
        bus_reqcyc = 1'b1; bus_req = addr; bus_reqtag = tag;
        step();
        chk("rd_addr_ack", bus_reqack, 1);
        chk("rd_ack_no_respcyc", bus_respcyc, 0);
        bus_reqcyc = busy;
        bus_req = {$urandom, $urandom};
        idle = 0;
        step();
        while (!bus_respcyc && idle < 50) begin
            chk("rd_wait_noack", bus_reqack, 0);
            chk("rd_wait_resp_zero", bus_resp, 0);
            idle++;
            step();
        end
        chk("rd_latency", idle, RL);
        for (int k = 0; k < NB; k++) begin
            if (k > 0) step();
            chk("rd_respcyc", bus_respcyc, 1);
            chk("rd_data", bus_resp, model[ln][k]);
            chk("rd_tag", bus_resptag, tag);
            chk("rd_noack", bus_reqack, 0);
            if (k == rst_beat) begin
                #2 reset = 1'b1;
                #1;
                chk("rst_respcyc", bus_respcyc, 0);
                chk("rst_resp", bus_resp, 0);
                chk("rst_resptag", bus_resptag, 0);
                chk("rst_reqack", bus_reqack, 0);
                bus_reqcyc = 1'b0; bus_respack = 1'b0;
                #2 reset = 1'b0;
                clear_model();
                repeat (4) begin
                    step();
                    chk("rst_no_respcyc", bus_respcyc, 0);
                end
                return;
            end
            held = bus_resp;
            d = int'($urandom_range(maxd, mind));
            bus_respack = 1'b0;
            repeat (d) begin
                step();
                chk("rd_hold_cyc", bus_respcyc, 1);
                chk("rd_hold_data", bus_resp, held);
                chk("rd_hold_tag", bus_resptag, tag);
            end
            bus_respack = 1'b1;
            if (k == NB - 1) bus_reqcyc = 1'b0;
            step();
            bus_respack = 1'b0;
            chk("rd_gap_low", bus_respcyc, 0);
            chk("rd_gap_resp", bus_resp, 0);
            chk("rd_gap_tag", bus_resptag, 0);
            chk("rd_gap_noack", bus_reqack, 0);
        end
    endtask

    initial begin
        int cnt;
        logic [63:0] a;
        reset = 1'b1;
        bus_reqcyc = 1'b0; bus_req = '0; bus_reqtag = '0; bus_respack = 1'b0;
        z_reqcyc = 1'b0; z_req = '0; z_reqtag = '0; z_respack = 1'b0;
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_reqack", bus_reqack, 0);
        chk("reset_respcyc", bus_respcyc, 0);
        chk("reset_resp", bus_resp, 0);
        chk("reset_resptag", bus_resptag, 0);
        reset = 1'b0;
        step();

        do_read(64'hC0, 13'h1005, 0, 0, 1'b0, -1);

        for (int k = 0; k < NB; k++) wbuf[k] = 64'(8'h11 * (k + 1));
        do_write(64'h140, 13'h0007, 0);
        do_read(64'h140, 13'h1ABC, 0, 0, 1'b0, -1);
        do_read(64'h140, 13'h1234, 3, 3, 1'b0, -1);

        for (int k = 0; k < NB; k++) wbuf[k] = {$urandom, $urandom};
        do_write(64'h40, 13'h0123, 0);
        do_read(64'h440, 13'h1F00, 0, 1, 1'b0, -1);
        do_read(64'h7F, 13'h1001, 0, 0, 1'b0, -1);
        do_read(64'h47, 13'h1777, 0, 2, 1'b1, -1);

        z_reqcyc = 1'b1; z_req = 64'h80; z_reqtag = 13'h1ABC;
        step();
        chk("z_ack", z_reqack, 1);
        z_reqcyc = 1'b0; z_respack = 1'b1;
        step();
        chk("z_lat0_respcyc", z_respcyc, 1);
        chk("z_lat0_tag", z_resptag, 13'h1ABC);
        cnt = 1;
        repeat (20) begin
            step();
            if (z_respcyc) cnt++;
        end
        chk("z_beat_count", cnt, NB);
        z_respack = 1'b0;

        for (int t = 0; t < 40; t++) begin
            a = {$urandom, $urandom};
            if ($urandom_range(1, 0) == 1) begin
                for (int k = 0; k < NB; k++) wbuf[k] = {$urandom, $urandom};
                do_write(a, {1'b0, 12'($urandom)}, 2);
            end else begin
                do_read(a, {1'b1, 12'($urandom)}, 0, 3, 1'($urandom_range(1, 0)), -1);
            end
        end

        for (int k = 0; k < NB; k++) wbuf[k] = {$urandom, $urandom};
        do_write(64'h140, 13'h0042, 0);
        do_read(64'h140, 13'h1111, 0, 0, 1'b0, 4);
        do_read(64'h140, 13'h1222, 0, 0, 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
